dma_reg_arbiter: RTL
====================

# dma_reg_arbiter

Round-robin arbiter that shares the single DMA register bus (wr_en, rd_en, addr, wdata, rdata) among up to four requesters, e.g. a host-side config master and the DMA descriptor fetcher. It accepts one command at a time and drives exactly one bus strobe per command. For reads it waits a fixed bus latency, captures rdata, and returns it to the originating requester. It sits directly in front of the DMA register block.

## Interface
- NUM_REQ, 2, number of requesters (legal 2..4)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, cycles from bus rd_en to valid bus rdata (legal 1..4)

Clocking: one clock; reset is synchronous and active-high.

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester command request
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i is at slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-cycle one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-cycle one-hot read-data-valid pulse
- rsp_rdata  out  DATA_W  read data, shared by all requesters, qualified by rsp_valid
- wr_en  out  1  bus write strobe
- rd_en  out  1  bus read strobe
- addr  out  ADDR_W  bus address
- wdata  out  DATA_W  bus write data
- rdata  in  DATA_W  bus read data
- busy  out  1  high in ISSUE and WAIT_RD

## Operation
- Requester contract: once req[i] is asserted, the requester holds req[i], req_we[i], req_addr[i] and req_wdata[i] stable until it samples gnt[i]=1. It may drop or re-assert req[i] in the cycle after gnt.
- Round-robin pointer last: reset value NUM_REQ-1, so requester 0 wins first. The winner is the first asserted req scanning last+1, last+2, … modulo NUM_REQ. last updates to the winner on grant only.
- FSM states: IDLE, ISSUE, WAIT_RD.
  - IDLE: if any req is high, register the winner's command onto addr/wdata, set wr_en or rd_en and gnt[winner], and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (one cycle): strobes and gnt are high for this cycle only. A write returns to IDLE. A read goes to WAIT_RD with counter = RD_LAT-1.
  - WAIT_RD: decrement the counter. When it reaches 0, capture rdata into rsp_rdata, set rsp_valid[owner] for the next cycle, and go to IDLE.
- addr/wdata hold their last values when idle; the bus qualifies them with the strobes only. wr_en and rd_en are never high together.
- A requester whose req is low when the read response returns still receives rsp_valid.
- Reset value of every output is 0: gnt, rsp_valid, rsp_rdata, wr_en, rd_en, addr, wdata, busy. State resets to IDLE and last to NUM_REQ-1.
- Reset during ISSUE or WAIT_RD abandons the transaction. No rsp_valid follows, and strobes are 0 from the cycle after rst is sampled.

## Timing
- All outputs are registered.
- Request seen in cycle T (state IDLE): gnt and strobe are high in T+1.
- Write throughput: one write per 2 cycles. IDLE in T+2 can arbitrate again, giving the next strobe in T+3.
- Read: rdata is sampled at the end of cycle T+1+RD_LAT. rsp_valid and rsp_rdata are valid in T+2+RD_LAT, with state IDLE in that same cycle. Request-to-response latency is RD_LAT+2 cycles.
- A new arbitration in the rsp_valid cycle is allowed. The next strobe and rsp_valid therefore never overlap on the same requester within one cycle.
- Simultaneous requests: one grant per arbitration. Losers stay pending and keep priority order per the pointer.
- rsp_rdata holds its value until the next read capture.

## Test plan
- Reset and idle: hold rst 3 cycles with req=0 -> all outputs 0 and busy=0. With no req after reset, the bus stays quiet indefinitely.
- Single write: req[0]=1, we=1, addr=0x10, wdata=0xDEADBEEF at T -> in T+1, gnt=0001, wr_en=1, addr=0x10, wdata=0xDEADBEEF. In T+2, wr_en=0.
- Single read, RD_LAT=1: req[1], addr=0x20, bus model returns 0xA5A5A5A5 in T+2 -> rd_en high only in T+1, and rsp_valid=0010 with rsp_rdata=0xA5A5A5A5 in T+3.
- Round-robin fairness: NUM_REQ=4, all req held high with writes -> grant order 0,1,2,3,0 with grants 2 cycles apart. Each requester drops req after its gnt, and no requester is granted twice before all others.
- Contention with read: req[0] read and req[2] write asserted together -> req0 granted first. The req2 write strobe appears only after rsp_valid[0], in the same cycle or later.
- Reset mid-read: RD_LAT=3, assert rst during WAIT_RD -> no rsp_valid. The next request after reset is granted to requester 0 by priority.

Source files
------------

// File: rtl/dma_reg_arbiter.sv
// Round-robin arbiter sharing one DMA register bus among NUM_REQ requesters.
// One command in flight at a time; reads wait RD_LAT cycles and return data to the owner.
module dma_reg_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       wr_en,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          addr,
  output logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W-1:0]          rdata,
  output logic                       busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_last, w_last_nxt;
  logic [IDX_W-1:0]    r_owner, w_owner_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                r_wr_en, w_wr_en_nxt;
  logic                r_rd_en, w_rd_en_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic                r_busy, w_busy_nxt;

  logic                w_found;
  logic [IDX_W-1:0]    w_win;
  logic [IDX_W-1:0]    w_idx;

  // Scan last+1, last+2, ... (mod NUM_REQ); the first asserted request wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((32'(r_last) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_owner_nxt     = r_owner;
    w_cnt_nxt       = r_cnt;
    w_gnt_nxt       = '0;
    w_rsp_valid_nxt = '0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_wr_en_nxt     = 1'b0;
    w_rd_en_nxt     = 1'b0;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt        = ST_ISSUE;
          w_gnt_nxt[w_win]   = 1'b1;
          w_wr_en_nxt        = req_we[w_win];
          w_rd_en_nxt        = !req_we[w_win];
          w_addr_nxt         = req_addr[32'(w_win)*ADDR_W +: ADDR_W];
          w_wdata_nxt        = req_wdata[32'(w_win)*DATA_W +: DATA_W];
          w_last_nxt         = w_win;
          w_owner_nxt        = w_win;
        end
      end
      ST_ISSUE: begin
        if (r_wr_en) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_RD;
          w_cnt_nxt   = CNT_W'(RD_LAT - 1);
        end
      end
      ST_WAIT_RD: begin
        if (r_cnt == '0) begin
          w_state_nxt              = ST_IDLE;
          w_rsp_rdata_nxt          = rdata;
          w_rsp_valid_nxt[r_owner] = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last      <= IDX_W'(NUM_REQ - 1);
      r_owner     <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_owner     <= w_owner_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign wr_en     = r_wr_en;
  assign rd_en     = r_rd_en;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign busy      = r_busy;

endmodule
